// File: rtl/feature_window_scheduler.sv
// Feature-window sequencer: walks [start, total_feat) in windows of SIMD_NUM*LANE_NUM,
// issuing each over valid/ready and waiting for the lane array's completion pulse.
module feature_window_scheduler #(
   parameter int unsigned FEAT_W   = 12,
   parameter int unsigned SIMD_NUM = 64,
   parameter int unsigned LANE_NUM = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              resume,
   input  logic [FEAT_W-1:0] total_feat,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [FEAT_W-1:0] win_lo,
   output logic [FEAT_W-1:0] win_hi,
   input  logic              blk_done,
   output logic              busy,
   output logic              all_done,
   output logic [FEAT_W-1:0] win_count
);

   localparam int unsigned   WIN   = SIMD_NUM * LANE_NUM;
   localparam logic [FEAT_W:0] WIN_X = (FEAT_W + 1)'(WIN);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DONE} state_t;

   state_t            state, state_nx;
   logic [FEAT_W-1:0] tot_r, cur, last_end, cnt, lo_r, hi_r;
   logic [FEAT_W:0]   sum;
   logic [FEAT_W-1:0] hi_calc;
   logic              exhausted, fire;

   // Window end is clamped to tot_r; the extra sum bit keeps cur+WIN from wrapping.
   always_comb begin
      sum       = {1'b0, cur} + WIN_X;
      hi_calc   = (sum > {1'b0, tot_r}) ? tot_r : sum[FEAT_W-1:0];
      exhausted = (cur >= tot_r);
   end

   always_comb begin
      state_nx  = state;
      win_valid = 1'b0;
      win_lo    = lo_r;
      win_hi    = hi_r;
      all_done  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) state_nx = ISSUE;
         end
         ISSUE: begin
            if (exhausted) begin
               state_nx = DONE;
            end else begin
               win_valid = 1'b1;
               win_lo    = cur;
               win_hi    = hi_calc;
               if (win_ready) state_nx = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (blk_done) state_nx = ISSUE;
         end
         DONE: begin
            all_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      fire = win_valid && win_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tot_r    <= '0;
         cur      <= '0;
         last_end <= '0;
         cnt      <= '0;
         lo_r     <= '0;
         hi_r     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            tot_r <= total_feat;
            cur   <= resume ? last_end : '0;
            cnt   <= '0;
         end
         // Accepted window is captured so it stays visible through WAIT_DONE.
         if (fire) begin
            cur      <= hi_calc;
            last_end <= hi_calc;
            cnt      <= cnt + FEAT_W'(1);
            lo_r     <= cur;
            hi_r     <= hi_calc;
         end
      end
   end

   assign win_count = cnt;

endmodule

// File: tb/tb_feature_window_scheduler.sv
// Self-checking bench for feature_window_scheduler: window-list model with per-cycle
// compare, plus directed runs with literal expectations for latency and boundaries.
module tb_feature_window_scheduler;

   localparam int FW  = 12;
   localparam int WIN = 2048;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          resume = 1'b0;
   logic [FW-1:0] total_feat = '0;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic [FW-1:0] win_lo, win_hi;
   logic          blk_done = 1'b0;
   logic          busy, all_done;
   logic [FW-1:0] win_count;

   feature_window_scheduler #(.FEAT_W(FW), .SIMD_NUM(64), .LANE_NUM(32)) dut (
      .clk(clk), .rst(rst), .start(start), .resume(resume), .total_feat(total_feat),
      .win_valid(win_valid), .win_ready(win_ready), .win_lo(win_lo), .win_hi(win_hi),
      .blk_done(blk_done), .busy(busy), .all_done(all_done), .win_count(win_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {int lo; int hi;} win_t;
   win_t m_q[$];
   int   m_cnt = 0;
   int   m_last = 0;
   bit   m_idle = 1'b1;
   int   done_pulses = 0;

   // Model: on an accepted start, list every window the run must issue; then every
   // offered descriptor must match the head of that list.
   always @(negedge clk) begin
      int lo, hi, t;
      if (rst) begin
         m_q.delete();
         m_cnt  = 0;
         m_last = 0;
         m_idle = 1'b1;
      end else begin
         chk("busy", busy, m_idle ? 0 : 1);
         chk("win_count", win_count, m_cnt);
         if (win_valid) begin
            if (m_q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               chk("win_lo", win_lo, m_q[0].lo);
               chk("win_hi", win_hi, m_q[0].hi);
               if (win_ready) begin
                  m_last = m_q[0].hi;
                  void'(m_q.pop_front());
                  m_cnt++;
               end
            end
         end
         if (m_idle && start) begin
            lo = resume ? m_last : 0;
            t  = total_feat;
            m_q.delete();
            while (lo < t) begin
               hi = (lo + WIN > t) ? t : lo + WIN;
               m_q.push_back('{lo, hi});
               lo = hi;
            end
            m_cnt  = 0;
            m_idle = 1'b0;
         end
         if (all_done) begin
            chk("done_windows_left", m_q.size(), 0);
            done_pulses++;
            m_idle = 1'b1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Iteration 0 is the start cycle; lane array answers lat cycles after each handshake.
   task automatic run(input bit pulse_start, input bit res, input int tot, input int lat,
                      input int stop_hs, output int nwin, output int t_valid, output int t_done,
                      output int blk2done, output int lo0, output int hi0, output int hi_last);
      int cnt, t_blk;
      bit got;
      cnt = -1; t_blk = -1; got = 1'b0;
      nwin = 0; t_valid = -1; t_done = -1; blk2done = -1; lo0 = -1; hi0 = -1; hi_last = -1;
      win_ready  = 1'b1;
      resume     = res;
      total_feat = FW'(tot);
      for (int i = 0; i < 400; i++) begin
         start    = pulse_start && (i == 0);
         blk_done = (cnt == 0);
         if (cnt == 0) t_blk = i;
         if (cnt >= 0) cnt--;
         if (win_valid) begin
            if (t_valid < 0) t_valid = i;
            if (lo0 < 0) begin
               lo0 = win_lo;
               hi0 = win_hi;
            end
            hi_last = win_hi;
            if (win_ready) begin
               nwin++;
               cnt = lat - 1;
            end
         end
         if (all_done) begin
            t_done   = i;
            blk2done = (t_blk < 0) ? -1 : i - t_blk;
            got      = 1'b1;
         end
         if (got || (stop_hs > 0 && nwin == stop_hs)) begin
            start    = 1'b0;
            blk_done = 1'b0;
            cyc();
            break;
         end
         cyc();
      end
      start    = 1'b0;
      blk_done = 1'b0;
      if (!got && stop_hs == 0) chk("run_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw, tv, td, bd, l0, h0, hl;

      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_valid", win_valid, 0);
      chk("rst_lo", win_lo, 0);
      chk("rst_hi", win_hi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_all_done", all_done, 0);
      chk("rst_count", win_count, 0);

      // Empty run, then resume from last_end=0.
      run(1, 0, 0, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("empty_nwin", nw, 0);
      chk("empty_done_at", td, 2);
      chk("empty_count", win_count, 0);
      chk("empty_idle_after", busy, 0);
      run(1, 1, 100, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("r100_nwin", nw, 1);
      chk("r100_valid_at", tv, 1);
      chk("r100_lo", l0, 0);
      chk("r100_hi", h0, 100);
      chk("r100_blk2done", bd, 2);

      // Two windows, last one partial.
      run(1, 0, 4095, 3, 0, nw, tv, td, bd, l0, h0, hl);
      chk("r4095_nwin", nw, 2);
      chk("r4095_valid_at", tv, 1);
      chk("r4095_lo0", l0, 0);
      chk("r4095_hi0", h0, 2048);
      chk("r4095_hi_last", hl, 4095);
      chk("r4095_count", win_count, 2);
      chk("r4095_blk2done", bd, 2);
      chk("model_last_end", m_last, 4095);

      // Exact fit.
      run(1, 0, 2048, 3, 0, nw, tv, td, bd, l0, h0, hl);
      chk("fit_nwin", nw, 1);
      chk("fit_hi", h0, 2048);
      chk("fit_blk2done", bd, 2);

      // Resume chain.
      run(1, 0, 1000, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("res1_nwin", nw, 1);
      chk("res1_hi", h0, 1000);
      run(1, 1, 3000, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("res2_nwin", nw, 1);
      chk("res2_lo", l0, 1000);
      chk("res2_hi", h0, 3000);
      run(1, 1, 3000, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("res3_nwin", nw, 0);
      chk("res3_done_at", td, 2);

      // Backpressure with stray blk_done and start while busy.
      win_ready  = 1'b0;
      resume     = 1'b0;
      total_feat = 12'd4095;
      start      = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", win_valid, 1);
         chk("bp_lo", win_lo, 0);
         chk("bp_hi", win_hi, 2048);
         blk_done = (k == 1);
         start    = (k == 2);
         if (k == 2) begin
            resume     = 1'b1;
            total_feat = 12'd500;
         end
         cyc();
      end
      blk_done = 1'b0;
      start    = 1'b0;
      run(0, 0, 4095, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("bp_nwin", nw, 2);
      chk("bp_lo0", l0, 0);
      chk("bp_hi0", h0, 2048);
      chk("bp_hi_last", hl, 4095);
      chk("bp_count", win_count, 2);

      // Reset while waiting on window 2, then resume must start from 0.
      run(1, 0, 4095, 3, 2, nw, tv, td, bd, l0, h0, hl);
      chk("mid_nwin", nw, 2);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      cyc();
      rst      = 1'b0;
      blk_done = 1'b1;
      chk("mid_rst_valid", win_valid, 0);
      chk("mid_rst_lo", win_lo, 0);
      chk("mid_rst_hi", win_hi, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_all_done", all_done, 0);
      chk("mid_rst_count", win_count, 0);
      cyc();
      blk_done = 1'b0;
      chk("mid_stray_busy", busy, 0);
      chk("mid_stray_valid", win_valid, 0);
      run(1, 1, 4095, 2, 0, nw, tv, td, bd, l0, h0, hl);
      chk("post_rst_lo0", l0, 0);
      chk("post_rst_nwin", nw, 2);

      chk("done_pulses", done_pulses, 9);
      repeat (2) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
